// File: rtl/wide_add_sequencer_pkg.sv
// Shared definitions for the wide add/subtract sequencer: slice width,
// controller state encoding and the slice-count legality check.
package wide_add_sequencer_pkg;

    localparam int SLICE_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // The sequencer supports between 2 and 8 slices of SLICE_W bits.
    function automatic bit words_legal(input int words);
        return (words >= 2) && (words <= 8);
    endfunction

endpackage

// File: rtl/wide_add_sequencer_if.sv
// Start/busy/done handshake plus operand and result bus of the sequencer.
interface wide_add_sequencer_if
    import wide_add_sequencer_pkg::*;
#(
    parameter int WORDS = 4
);
    localparam int W = SLICE_W * WORDS;

    logic         start;
    logic         sub;
    logic [W-1:0] opA;
    logic [W-1:0] opB;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;

    modport master (
        output start, sub, opA, opB,
        input  ready, busy, done, result, cout, ovf
    );

    modport slave (
        input  start, sub, opA, opB,
        output ready, busy, done, result, cout, ovf
    );

endinterface

// File: rtl/wide_add_sequencer_carry_lookahead16.sv
// 16-bit carry-lookahead adder: four 4-bit lookahead groups joined by a
// second lookahead level over the group generate/propagate terms.
module carry_lookahead16 (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    input  logic        i_cin,
    output logic [15:0] o_sum,
    output logic        o_cout
);
    logic [15:0] w_p;
    logic [15:0] w_g;
    logic [3:0]  w_gg;
    logic [3:0]  w_gp;
    logic [4:0]  w_gc;
    logic [15:0] w_c;

    // Bit and group generate/propagate terms.
    always_comb begin
        w_p  = i_a ^ i_b;
        w_g  = i_a & i_b;
        w_gg = 4'b0000;
        w_gp = 4'b0000;
        for (int j = 0; j < 4; j++) begin
            w_gg[j] = w_g[4*j+3]
                    | (w_p[4*j+3] & w_g[4*j+2])
                    | (w_p[4*j+3] & w_p[4*j+2] & w_g[4*j+1])
                    | (w_p[4*j+3] & w_p[4*j+2] & w_p[4*j+1] & w_g[4*j]);
            w_gp[j] = &w_p[4*j +: 4];
        end
    end

    // Second-level lookahead produces every group carry directly from Cin.
    assign w_gc[0] = i_cin;
    assign w_gc[1] = w_gg[0] | (w_gp[0] & i_cin);
    assign w_gc[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & i_cin);
    assign w_gc[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                   | (w_gp[2] & w_gp[1] & w_gp[0] & i_cin);
    assign w_gc[4] = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
                   | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
                   | (w_gp[3] & w_gp[2] & w_gp[1] & w_gp[0] & i_cin);

    // Per-bit carries inside each group, expanded from that group's carry-in.
    always_comb begin
        w_c = 16'h0000;
        for (int j = 0; j < 4; j++) begin
            w_c[4*j]   = w_gc[j];
            w_c[4*j+1] = w_g[4*j] | (w_p[4*j] & w_gc[j]);
            w_c[4*j+2] = w_g[4*j+1] | (w_p[4*j+1] & w_g[4*j])
                       | (w_p[4*j+1] & w_p[4*j] & w_gc[j]);
            w_c[4*j+3] = w_g[4*j+2] | (w_p[4*j+2] & w_g[4*j+1])
                       | (w_p[4*j+2] & w_p[4*j+1] & w_g[4*j])
                       | (w_p[4*j+2] & w_p[4*j+1] & w_p[4*j] & w_gc[j]);
        end
    end

    assign o_sum  = w_p ^ w_c;
    assign o_cout = w_gc[4];

endmodule

// File: rtl/wide_add_sequencer.sv
// Multi-cycle W-bit add/subtract: one 16-bit slice per clock through a
// single shared carry_lookahead16, LSB slice first, carry held between slices.
module wide_add_sequencer
    import wide_add_sequencer_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                clk,
    input  logic                rst,
    wide_add_sequencer_if.slave bus
);
    localparam int W     = SLICE_W * WORDS;
    localparam int IDX_W = $clog2(WORDS);

    if (!words_legal(WORDS)) begin : g_words_illegal
        $error("wide_add_sequencer: WORDS must lie in 2..8");
    end

    state_t             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic               r_carry;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_result;
    logic               r_cout;
    logic               r_ovf;
    logic               r_done;
    logic               r_busy;
    logic               r_ready;

    logic [SLICE_W-1:0] w_a_slice;
    logic [SLICE_W-1:0] w_b_slice;
    logic [SLICE_W-1:0] w_sum;
    logic               w_cout;
    logic               w_last;
    logic               w_ovf;

    // Slice mux: present the current operand slice pair to the shared adder.
    always_comb begin
        w_a_slice = r_a[int'(r_idx)*SLICE_W +: SLICE_W];
        w_b_slice = r_b[int'(r_idx)*SLICE_W +: SLICE_W];
    end

    carry_lookahead16 u_slice_adder (
        .i_a    (w_a_slice),
        .i_b    (w_b_slice),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // b_r already holds ~opB for subtract, so this is the usual signed test.
    assign w_last = (r_idx == IDX_W'(WORDS - 1));
    assign w_ovf  = (r_a[W-1] == r_b[W-1]) && (w_sum[SLICE_W-1] != r_a[W-1]);

    // Controller: operand capture, slice stepping, carry chaining and flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
            r_ready  <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_a     <= bus.opA;
                        r_b     <= bus.sub ? ~bus.opB : bus.opB;
                        r_carry <= bus.sub;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_ready <= 1'b0;
                        r_state <= RUN;
                    end else begin
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                    end
                end
                RUN: begin
                    r_result[int'(r_idx)*SLICE_W +: SLICE_W] <= w_sum;
                    r_carry <= w_cout;
                    if (w_last) begin
                        r_cout  <= w_cout;
                        r_ovf   <= w_ovf;
                        r_idx   <= '0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_idx   <= r_idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_idx   <= '0;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready  = r_ready;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;
    assign bus.cout   = r_cout;
    assign bus.ovf    = r_ovf;

endmodule
